fetch_inst_queue: RTL and testbench

- Instruction queue between the fetch stage and decode; decouples fetch from decode stalls.
- Captures {PC, instruction, fetch exception flags} from fetch and presents them in order to decode over a valid/ready handshake.
- Flushed on any front-end redirect.
- After an exception entry is enqueued, it stops accepting fetch pushes until the next flush.

---
 rtl/fetch_inst_queue.sv | 144 ++++++++++++++
 tb/tb_fetch_inst_queue.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_inst_queue.sv
// fetch_inst_queue: in-order instruction queue between fetch and decode.
// Holds {PC, instruction, fetch exception flags} in a circular buffer and
// presents the oldest entry to decode. A front-end redirect (FLUSH) empties
// it; once an exception entry has been accepted, no more fetch pushes are
// taken until the next flush or reset.
//
// Handshake: an entry moves only when the producer's valid and the consumer's
// ready are both high in the same cycle, and FLUSH is low. QUEUE_READY comes
// from registered state only, so it never depends on DEC_READY. DEC_VALID and
// the DEC_* head fields also come from registered state only. While FETCH_VALID
// is high and QUEUE_READY is low, fetch holds its entry and the queue ignores it.
module fetch_inst_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 40,
    parameter int INST_W = 32
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     FLUSH,
    input  logic                     FETCH_VALID,
    input  logic [ADDR_W-1:0]        FETCH_PC,
    input  logic [INST_W-1:0]        FETCH_INST,
    input  logic                     FETCH_XCPT_IF,
    input  logic                     FETCH_XCPT_MISALIGNED,
    output logic                     QUEUE_READY,
    output logic                     DEC_VALID,
    input  logic                     DEC_READY,
    output logic [ADDR_W-1:0]        DEC_PC,
    output logic [INST_W-1:0]        DEC_INST,
    output logic                     DEC_XCPT_IF,
    output logic                     DEC_XCPT_MISALIGNED,
    output logic [$clog2(DEPTH):0]   QUEUE_COUNT
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic {
        ST_RUN        = 1'b0,
        ST_XCPT_BLOCK = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [ADDR_W-1:0]  pc_mem_q   [DEPTH];
    logic [INST_W-1:0]  inst_mem_q [DEPTH];
    logic               xif_mem_q  [DEPTH];
    logic               xmis_mem_q [DEPTH];

    logic push;
    logic pop;
    logic push_xcpt;

    // Accept/consume qualification; FLUSH kills both.
    always_comb begin
        QUEUE_READY = (state_q == ST_RUN) && (count_q < DEPTH_C);
        DEC_VALID   = (count_q != '0);
        push        = FETCH_VALID && QUEUE_READY && !FLUSH;
        pop         = DEC_VALID && DEC_READY && !FLUSH;
        push_xcpt   = push && (FETCH_XCPT_IF || FETCH_XCPT_MISALIGNED);
        QUEUE_COUNT = count_q;
    end

    // Next-state for pointers, occupancy and the accept/block FSM.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        state_d  = state_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (push_xcpt) begin
            state_d = ST_XCPT_BLOCK;
        end
        if (FLUSH) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            state_d  = ST_RUN;
        end
    end

    // Control state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_RUN;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage: cleared on reset, written at wr_ptr on an accepted push.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                inst_mem_q[i] <= '0;
                xif_mem_q[i]  <= 1'b0;
                xmis_mem_q[i] <= 1'b0;
            end
        end else if (push) begin
            pc_mem_q[wr_ptr_q]   <= FETCH_PC;
            inst_mem_q[wr_ptr_q] <= FETCH_INST;
            xif_mem_q[wr_ptr_q]  <= FETCH_XCPT_IF;
            xmis_mem_q[wr_ptr_q] <= FETCH_XCPT_MISALIGNED;
        end
    end

    // Head presentation: zeros when empty; instruction masked on exception entries.
    always_comb begin
        DEC_PC              = '0;
        DEC_INST            = '0;
        DEC_XCPT_IF         = 1'b0;
        DEC_XCPT_MISALIGNED = 1'b0;
        if (count_q != '0) begin
            DEC_PC              = pc_mem_q[rd_ptr_q];
            DEC_XCPT_IF         = xif_mem_q[rd_ptr_q];
            DEC_XCPT_MISALIGNED = xmis_mem_q[rd_ptr_q];
            if (!(xif_mem_q[rd_ptr_q] || xmis_mem_q[rd_ptr_q])) begin
                DEC_INST = inst_mem_q[rd_ptr_q];
            end
        end
    end

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Testbench for fetch_inst_queue: hand-derived vector table, directed
// multi-cycle sequences, and randomized traffic against a queue-based model.
module tb_fetch_inst_queue;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 40;
    localparam int INST_W = 32;
    localparam int ENT_W  = ADDR_W + INST_W + 2;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, flush, fetch_valid, fetch_xif, fetch_xmis, dec_ready;
    logic [ADDR_W-1:0] fetch_pc;
    logic [INST_W-1:0] fetch_inst;
    logic              queue_ready, dec_valid, dec_xif, dec_xmis;
    logic [ADDR_W-1:0] dec_pc;
    logic [INST_W-1:0] dec_inst;
    logic [2:0]        queue_count;

    fetch_inst_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INST_W(INST_W)) dut (
        .CLK                   (clk),
        .RST                   (rst),
        .FLUSH                 (flush),
        .FETCH_VALID           (fetch_valid),
        .FETCH_PC              (fetch_pc),
        .FETCH_INST            (fetch_inst),
        .FETCH_XCPT_IF         (fetch_xif),
        .FETCH_XCPT_MISALIGNED (fetch_xmis),
        .QUEUE_READY           (queue_ready),
        .DEC_VALID             (dec_valid),
        .DEC_READY             (dec_ready),
        .DEC_PC                (dec_pc),
        .DEC_INST              (dec_inst),
        .DEC_XCPT_IF           (dec_xif),
        .DEC_XCPT_MISALIGNED   (dec_xmis),
        .QUEUE_COUNT           (queue_count)
    );

    int n_vec = 0;
    int n_err = 0;

    // reference model: queue of packed {pc, inst, xif, xmis} plus a block flag
    logic [ENT_W-1:0] exp_q[$];
    logic             m_block;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver: apply one cycle of inputs, compare against the model, clock, update model
    task automatic step(input logic r, input logic f, input logic fv,
                        input logic [ADDR_W-1:0] pc, input logic [INST_W-1:0] inst,
                        input logic xif, input logic xmis, input logic dr);
        logic [ENT_W-1:0] head;
        logic             m_ready, m_valid, m_hx;
        rst = r; flush = f; fetch_valid = fv; fetch_pc = pc; fetch_inst = inst;
        fetch_xif = xif; fetch_xmis = xmis; dec_ready = dr;
        #1;
        m_ready = !m_block && (exp_q.size() < DEPTH);
        m_valid = (exp_q.size() != 0);
        head    = m_valid ? exp_q[0] : '0;
        m_hx    = head[1] | head[0];
        check("model_ready", 64'(queue_ready), 64'(m_ready));
        check("model_valid", 64'(dec_valid), 64'(m_valid));
        check("model_count", 64'(queue_count), 64'(exp_q.size()));
        check("model_pc", 64'(dec_pc), 64'(head[ENT_W-1 -: ADDR_W]));
        check("model_inst", 64'(dec_inst), m_hx ? 64'(0) : 64'(head[INST_W+1:2]));
        check("model_xif", 64'(dec_xif), 64'(head[1]));
        check("model_xmis", 64'(dec_xmis), 64'(head[0]));
        @(posedge clk);
        if (r || f) begin
            exp_q.delete();
            m_block = 1'b0;
        end else begin
            if (m_valid && dr) void'(exp_q.pop_front());
            if (fv && m_ready) begin
                exp_q.push_back({pc, inst, xif, xmis});
                if (xif || xmis) m_block = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic              rst, flush, fv;
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
        logic              xif, xmis, dr;
        logic              e_ready, e_valid;
        logic [ADDR_W-1:0] e_pc;
        logic [INST_W-1:0] e_inst;
        logic              e_xif, e_xmis;
        logic [2:0]        e_cnt;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic f, input logic fv,
                                input logic [ADDR_W-1:0] pc, input logic [INST_W-1:0] inst,
                                input logic xif, input logic xmis, input logic dr,
                                input logic e_ready, input logic e_valid,
                                input logic [ADDR_W-1:0] e_pc, input logic [INST_W-1:0] e_inst,
                                input logic e_xif, input logic e_xmis, input logic [2:0] e_cnt);
        vec_t v;
        v.rst = r; v.flush = f; v.fv = fv; v.pc = pc; v.inst = inst;
        v.xif = xif; v.xmis = xmis; v.dr = dr;
        v.e_ready = e_ready; v.e_valid = e_valid; v.e_pc = e_pc; v.e_inst = e_inst;
        v.e_xif = e_xif; v.e_xmis = e_xmis; v.e_cnt = e_cnt;
        return v;
    endfunction

    vec_t tbl[24];

    initial begin
        // expected outputs are those seen during the cycle, before its rising edge
        //            rst f fv pc          inst        xif xmis dr | rdy vld e_pc        e_inst xif xmis cnt
        // fill with decode stalled, 5th push refused, then drain in order
        tbl[0]  = mk(0, 0, 1, 40'h100, 32'hA0, 0, 0, 0,   1, 0, 40'h0,   32'h0,  0, 0, 3'd0);
        tbl[1]  = mk(0, 0, 1, 40'h104, 32'hA1, 0, 0, 0,   1, 1, 40'h100, 32'hA0, 0, 0, 3'd1);
        tbl[2]  = mk(0, 0, 1, 40'h108, 32'hA2, 0, 0, 0,   1, 1, 40'h100, 32'hA0, 0, 0, 3'd2);
        tbl[3]  = mk(0, 0, 1, 40'h10C, 32'hA3, 0, 0, 0,   1, 1, 40'h100, 32'hA0, 0, 0, 3'd3);
        tbl[4]  = mk(0, 0, 1, 40'h110, 32'hA4, 0, 0, 0,   0, 1, 40'h100, 32'hA0, 0, 0, 3'd4);
        tbl[5]  = mk(0, 0, 0, 40'h0,   32'h0,  0, 0, 1,   0, 1, 40'h100, 32'hA0, 0, 0, 3'd4);
        tbl[6]  = mk(0, 0, 0, 40'h0,   32'h0,  0, 0, 1,   1, 1, 40'h104, 32'hA1, 0, 0, 3'd3);
        tbl[7]  = mk(0, 0, 0, 40'h0,   32'h0,  0, 0, 1,   1, 1, 40'h108, 32'hA2, 0, 0, 3'd2);
        tbl[8]  = mk(0, 0, 0, 40'h0,   32'h0,  0, 0, 1,   1, 1, 40'h10C, 32'hA3, 0, 0, 3'd1);
        tbl[9]  = mk(0, 0, 0, 40'h0,   32'h0,  0, 0, 0,   1, 0, 40'h0,   32'h0,  0, 0, 3'd0);
        // misaligned entry: instruction masked, pushes blocked until flush
        tbl[10] = mk(0, 0, 1, 40'h200, 32'hDEADBEEF, 0, 1, 0, 1, 0, 40'h0, 32'h0, 0, 0, 3'd0);
        tbl[11] = mk(0, 0, 1, 40'h204, 32'h13, 0, 0, 0,   0, 1, 40'h200, 32'h0,  0, 1, 3'd1);
        tbl[12] = mk(0, 0, 1, 40'h204, 32'h13, 0, 0, 1,   0, 1, 40'h200, 32'h0,  0, 1, 3'd1);
        tbl[13] = mk(0, 0, 1, 40'h204, 32'h13, 0, 0, 1,   0, 0, 40'h0,   32'h0,  0, 0, 3'd0);
        tbl[14] = mk(0, 1, 1, 40'h204, 32'h13, 0, 0, 0,   0, 0, 40'h0,   32'h0,  0, 0, 3'd0);
        tbl[15] = mk(0, 0, 0, 40'h0,   32'h0,  0, 0, 0,   1, 0, 40'h0,   32'h0,  0, 0, 3'd0);
        // two entries then blocked; reset clears everything; push after reset
        tbl[16] = mk(0, 0, 1, 40'h300, 32'h11, 0, 0, 0,   1, 0, 40'h0,   32'h0,  0, 0, 3'd0);
        tbl[17] = mk(0, 0, 1, 40'h304, 32'h22, 1, 0, 0,   1, 1, 40'h300, 32'h11, 0, 0, 3'd1);
        tbl[18] = mk(0, 0, 1, 40'h308, 32'h44, 0, 0, 0,   0, 1, 40'h300, 32'h11, 0, 0, 3'd2);
        tbl[19] = mk(1, 0, 1, 40'h30C, 32'h55, 0, 0, 1,   0, 1, 40'h300, 32'h11, 0, 0, 3'd2);
        tbl[20] = mk(0, 0, 1, 40'h80000000, 32'h33, 0, 0, 0, 1, 0, 40'h0, 32'h0, 0, 0, 3'd0);
        tbl[21] = mk(0, 0, 0, 40'h0,   32'h0,  0, 0, 0,   1, 1, 40'h80000000, 32'h33, 0, 0, 3'd1);
        tbl[22] = mk(0, 0, 0, 40'h0,   32'h0,  0, 0, 1,   1, 1, 40'h80000000, 32'h33, 0, 0, 3'd1);
        tbl[23] = mk(0, 0, 0, 40'h0,   32'h0,  0, 0, 0,   1, 0, 40'h0,   32'h0,  0, 0, 3'd0);

        // reset
        rst = 1'b1; flush = 1'b0; fetch_valid = 1'b0; fetch_pc = '0; fetch_inst = '0;
        fetch_xif = 1'b0; fetch_xmis = 1'b0; dec_ready = 1'b0;
        exp_q.delete();
        m_block = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // table vectors
        for (int i = 0; i < 24; i++) begin
            check($sformatf("t%0d_ready", i), 64'(queue_ready), 64'(tbl[i].e_ready));
            check($sformatf("t%0d_valid", i), 64'(dec_valid), 64'(tbl[i].e_valid));
            check($sformatf("t%0d_pc", i), 64'(dec_pc), 64'(tbl[i].e_pc));
            check($sformatf("t%0d_inst", i), 64'(dec_inst), 64'(tbl[i].e_inst));
            check($sformatf("t%0d_xif", i), 64'(dec_xif), 64'(tbl[i].e_xif));
            check($sformatf("t%0d_xmis", i), 64'(dec_xmis), 64'(tbl[i].e_xmis));
            check($sformatf("t%0d_count", i), 64'(queue_count), 64'(tbl[i].e_cnt));
            step(tbl[i].rst, tbl[i].flush, tbl[i].fv, tbl[i].pc, tbl[i].inst,
                 tbl[i].xif, tbl[i].xmis, tbl[i].dr);
        end

        // streaming from empty: one push per cycle, decode always ready
        for (int i = 0; i < 12; i++) begin
            if (i == 0 || i == 11) begin
                check("stream_valid", 64'(dec_valid), 64'(0));
                check("stream_count", 64'(queue_count), 64'(0));
            end else begin
                check("stream_valid", 64'(dec_valid), 64'(1));
                check("stream_count", 64'(queue_count), 64'(1));
                check("stream_pc", 64'(dec_pc), 64'(40'h1000 + 40'(4 * (i - 1))));
            end
            step(0, 0, (i < 10), 40'h1000 + 40'(4 * i), 32'(i), 0, 0, 1);
        end

        // flush at count 3 with simultaneous push and pop
        for (int i = 0; i < 3; i++) step(0, 0, 1, 40'h500 + 40'(4 * i), 32'h5, 0, 0, 0);
        check("flush_pre_count", 64'(queue_count), 64'(3));
        step(0, 1, 1, 40'hBAD0, 32'hBAD, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            check("flush_count", 64'(queue_count), 64'(0));
            check("flush_valid", 64'(dec_valid), 64'(0));
            check("flush_pc", 64'(dec_pc), 64'(0));
            step(0, 0, 0, '0, '0, 0, 0, 0);
        end

        // full with simultaneous pop: push refused, accepted the cycle after
        for (int i = 0; i < 4; i++) step(0, 0, 1, 40'h600 + 40'(4 * i), 32'h6, 0, 0, 0);
        check("full_ready", 64'(queue_ready), 64'(0));
        check("full_count", 64'(queue_count), 64'(4));
        step(0, 0, 1, 40'h610, 32'h61, 0, 0, 1);
        check("full_pop_count", 64'(queue_count), 64'(3));
        check("full_pop_ready", 64'(queue_ready), 64'(1));
        check("full_pop_pc", 64'(dec_pc), 64'(40'h604));
        step(0, 0, 1, 40'h610, 32'h61, 0, 0, 0);
        check("full_again_count", 64'(queue_count), 64'(4));
        check("full_again_ready", 64'(queue_ready), 64'(0));
        step(0, 1, 0, '0, '0, 0, 0, 0);

        // randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5,
                 $urandom_range(0, 99) < 70, {8'($urandom), 32'($urandom)}, 32'($urandom),
                 $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 60);
        end

        // report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
